part_cmd_responder: RTL and testbench

//  Command engine inside the part tester, on the DUT side of the serial link. Takes bytes

---
 rtl/part_cmd_responder.sv | 343 ++++++++++++++++++++++++++++++++++
 tb/tb_part_cmd_responder.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/part_cmd_responder.sv
// Purpose : host-command engine driving a part under test (scan, PIs/POs, clocks, reset).
// Latency : a command byte is decoded on the clk it arrives; replies go out one byte at a time.
// Backpress: each reply byte waits for tx_ready to fall and rise; bytes arriving outside receive states are dropped.
//
// Ports:
//   clk, rst               system clock, asynchronous active-high reset
//   rx_valid, rx_data      received byte strobe / value
//   tx_ready, tx_start,    uart_tx handshake: tx_start pulses while tx_ready=1,
//   tx_data                tx_data held until tx_ready rises again
//   part_clk, part_rstn,   part clock pulse, part reset (active-low),
//   part_se, part_tm       scan enable, test mode
//   scan_in, scan_out      scan chain serial in / out
//   part_pis_o[1:NPIS]     part primary inputs
//   part_pos_i[1:NPOS]     part primary outputs
//   idle                   high only while waiting for a command byte
// Optional feature: define PART_CMD_TIMEOUT_EN for an inter-byte watchdog that replies '!'.

module part_cmd_responder #(
    parameter int NPIS           = 14,
    parameter int NPOS           = 11,
    parameter int RST_CYCLES     = 16,
    parameter int TIMEOUT_CYCLES = 50000000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            rx_valid,
    input  logic [7:0]      rx_data,
    input  logic            tx_ready,
    output logic            tx_start,
    output logic [7:0]      tx_data,
    output logic            part_clk,
    output logic            part_rstn,
    output logic            part_se,
    output logic            part_tm,
    output logic            scan_in,
    input  logic            scan_out,
    output logic [1:NPIS]   part_pis_o,
    input  logic [1:NPOS]   part_pos_i,
    output logic            idle
);

    localparam logic [7:0] CH_S  = 8'h73;
    localparam logic [7:0] CH_G  = 8'h67;
    localparam logic [7:0] CH_I  = 8'h69;
    localparam logic [7:0] CH_O  = 8'h6F;
    localparam logic [7:0] CH_E  = 8'h65;
    localparam logic [7:0] CH_R  = 8'h72;
    localparam logic [7:0] CH_F  = 8'h66;
    localparam logic [7:0] CH_P  = 8'h70;
    localparam logic [7:0] CH_0  = 8'h30;
    localparam logic [7:0] CH_1  = 8'h31;
    localparam logic [7:0] CH_Q  = 8'h3F;
    localparam logic [7:0] CH_EX = 8'h21;
    localparam logic [7:0] CH_NL = 8'h0A;

    localparam logic [15:0] RST_LAST = 16'(RST_CYCLES - 1);
    localparam logic [15:0] RST_DONE = 16'(RST_CYCLES);

    typedef enum logic [3:0] {
        S_IDLE, S_CNT_HI, S_CNT_LO, S_RST, S_SET_RX, S_SHIFT, S_GET_TX,
        S_GET_SH, S_PI_RX, S_PO_TX, S_EXEC, S_FREE, S_ERR_TX
    } state_t;

    state_t         state_q;
    logic [7:0]     cmd_q;
    logic [15:0]    cnt_q;
    logic [15:0]    idx_q;
    logic [15:0]    rcnt_q;
    logic           ph_q;       // pulse phase: 0 = part_clk about to rise, 1 = about to fall
    logic           stop_q;     // 'p' seen while free-running
    logic [1:0]     tx_ph_q;    // 0 ready to start, 1 wait tx_ready fall, 2 wait rise
    logic [7:0]     tx_char_q;
    logic           tx_start_q;
    logic [7:0]     tx_data_q;
    logic           part_clk_q;
    logic           part_rstn_q;
    logic           part_se_q;
    logic           part_tm_q;
    logic           scan_in_q;
    logic [1:NPIS]  pis_q;

    logic           to_hit;

`ifdef PART_CMD_TIMEOUT_EN
    localparam logic [31:0] TO_LIMIT = 32'(TIMEOUT_CYCLES);
    logic [31:0]    to_cnt_q;

    // Watchdog: restarts on every received byte, saturates at the limit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            to_cnt_q <= '0;
        end else if (rx_valid) begin
            to_cnt_q <= '0;
        end else if (to_cnt_q != TO_LIMIT) begin
            to_cnt_q <= to_cnt_q + 32'd1;
        end
    end

    assign to_hit = (to_cnt_q == TO_LIMIT) &&
                    (state_q == S_CNT_HI || state_q == S_CNT_LO ||
                     state_q == S_SET_RX || state_q == S_PI_RX);
`else
    logic timeout_unused;
    assign timeout_unused = (TIMEOUT_CYCLES != 0);
    assign to_hit = 1'b0;
`endif

    logic           n_last;
    logic           pos_bit;
    logic [7:0]     tx_byte;
    logic           tx_active;
    logic           tx_done;

    assign n_last = (idx_q == cnt_q);

    always_comb begin
        pos_bit = 1'b0;
        for (int k = 1; k <= NPOS; k++) begin
            if (idx_q == 16'(k)) pos_bit = part_pos_i[k];
        end
    end

    always_comb begin
        tx_byte = tx_char_q;
        case (state_q)
            S_GET_TX: tx_byte = {7'b0011000, scan_out};
            S_PO_TX:  tx_byte = {7'b0011000, pos_bit};
            default:  tx_byte = tx_char_q;
        endcase
    end

    // The reset command shares the byte sender once its low phase is over.
    assign tx_active = (state_q == S_GET_TX) || (state_q == S_PO_TX) ||
                       (state_q == S_ERR_TX) ||
                       (state_q == S_RST && rcnt_q == RST_DONE);
    assign tx_done   = tx_active && (tx_ph_q == 2'd2) && tx_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cmd_q       <= '0;
            cnt_q       <= '0;
            idx_q       <= '0;
            rcnt_q      <= '0;
            ph_q        <= 1'b0;
            stop_q      <= 1'b0;
            tx_ph_q     <= 2'd0;
            tx_char_q   <= '0;
            tx_start_q  <= 1'b0;
            tx_data_q   <= '0;
            part_clk_q  <= 1'b0;
            part_rstn_q <= 1'b0;
            part_se_q   <= 1'b0;
            part_tm_q   <= 1'b0;
            scan_in_q   <= 1'b0;
            pis_q       <= '0;
        end else begin
            tx_start_q  <= 1'b0;
            part_rstn_q <= 1'b1;

            if (tx_active) begin
                case (tx_ph_q)
                    2'd0: if (tx_ready) begin
                        tx_start_q <= 1'b1;
                        tx_data_q  <= tx_byte;
                        tx_ph_q    <= 2'd1;
                    end
                    2'd1: if (!tx_ready) tx_ph_q <= 2'd2;
                    default: if (tx_ready) tx_ph_q <= 2'd0;
                endcase
            end

            case (state_q)
                S_IDLE: begin
                    if (rx_valid) begin
                        case (rx_data)
                            CH_S, CH_G, CH_I, CH_O, CH_E: begin
                                cmd_q   <= rx_data;
                                state_q <= S_CNT_HI;
                            end
                            CH_R: begin
                                rcnt_q      <= '0;
                                part_rstn_q <= 1'b0;
                                tx_char_q   <= CH_NL;
                                state_q     <= S_RST;
                            end
                            CH_F: begin
                                stop_q  <= 1'b0;
                                ph_q    <= 1'b0;
                                state_q <= S_FREE;
                            end
                            CH_P: ;
                            default: begin
                                tx_char_q <= CH_Q;
                                state_q   <= S_ERR_TX;
                            end
                        endcase
                    end
                end
                S_CNT_HI: begin
                    if (rx_valid) begin
                        cnt_q[15:8] <= rx_data;
                        state_q     <= S_CNT_LO;
                    end else if (to_hit) begin
                        tx_char_q <= CH_EX;
                        state_q   <= S_ERR_TX;
                    end
                end
                S_CNT_LO: begin
                    if (rx_valid) begin
                        cnt_q[7:0] <= rx_data;
                        idx_q      <= 16'd1;
                        ph_q       <= 1'b0;
                        if ({cnt_q[15:8], rx_data} == 16'd0) begin
                            state_q <= S_IDLE;
                        end else begin
                            case (cmd_q)
                                CH_S: begin
                                    part_se_q <= 1'b1;
                                    part_tm_q <= 1'b1;
                                    state_q   <= S_SET_RX;
                                end
                                CH_G: begin
                                    part_se_q <= 1'b1;
                                    state_q   <= S_GET_TX;
                                end
                                CH_I:    state_q <= S_PI_RX;
                                CH_O:    state_q <= S_PO_TX;
                                default: state_q <= S_EXEC;
                            endcase
                        end
                    end else if (to_hit) begin
                        tx_char_q <= CH_EX;
                        state_q   <= S_ERR_TX;
                    end
                end
                S_SET_RX: begin
                    if (rx_valid) begin
                        if (rx_data == CH_0 || rx_data == CH_1) begin
                            scan_in_q <= rx_data[0];
                            ph_q      <= 1'b0;
                            state_q   <= S_SHIFT;
                        end else begin
                            tx_char_q <= CH_Q;
                            state_q   <= S_ERR_TX;
                        end
                    end else if (to_hit) begin
                        tx_char_q <= CH_EX;
                        state_q   <= S_ERR_TX;
                    end
                end
                S_SHIFT, S_GET_SH, S_EXEC: begin
                    // scan_in/part_se settle one clk before the rising part_clk edge
                    if (!ph_q) begin
                        part_clk_q <= 1'b1;
                        ph_q       <= 1'b1;
                    end else begin
                        part_clk_q <= 1'b0;
                        ph_q       <= 1'b0;
                        if (n_last) begin
                            part_se_q <= 1'b0;
                            part_tm_q <= 1'b0;
                            state_q   <= S_IDLE;
                        end else begin
                            idx_q <= idx_q + 16'd1;
                            if (state_q == S_SHIFT)       state_q <= S_SET_RX;
                            else if (state_q == S_GET_SH) state_q <= S_GET_TX;
                        end
                    end
                end
                S_GET_TX: begin
                    if (tx_done) begin
                        ph_q    <= 1'b0;
                        state_q <= S_GET_SH;
                    end
                end
                S_PI_RX: begin
                    if (rx_valid) begin
                        for (int k = 1; k <= NPIS; k++) begin
                            if (idx_q == 16'(k)) pis_q[k] <= (rx_data == CH_1);
                        end
                        if (n_last) state_q <= S_IDLE;
                        else        idx_q   <= idx_q + 16'd1;
                    end else if (to_hit) begin
                        tx_char_q <= CH_EX;
                        state_q   <= S_ERR_TX;
                    end
                end
                S_PO_TX: begin
                    if (tx_done) begin
                        if (n_last) state_q <= S_IDLE;
                        else        idx_q   <= idx_q + 16'd1;
                    end
                end
                S_FREE: begin
                    // A 'p' ends the run at the next clk; a high part_clk is lowered on the way out.
                    if (rx_valid && rx_data == CH_P) stop_q <= 1'b1;
                    if (!ph_q) begin
                        if (stop_q || (rx_valid && rx_data == CH_P)) begin
                            state_q <= S_IDLE;
                        end else begin
                            part_clk_q <= 1'b1;
                            ph_q       <= 1'b1;
                        end
                    end else begin
                        part_clk_q <= 1'b0;
                        ph_q       <= 1'b0;
                        if (stop_q || (rx_valid && rx_data == CH_P)) state_q <= S_IDLE;
                    end
                end
                S_RST: begin
                    if (rcnt_q < RST_LAST) begin
                        part_rstn_q <= 1'b0;
                        rcnt_q      <= rcnt_q + 16'd1;
                    end else if (rcnt_q == RST_LAST) begin
                        rcnt_q <= RST_DONE;
                    end else if (tx_done) begin
                        state_q <= S_IDLE;
                    end
                end
                S_ERR_TX: begin
                    if (tx_done) begin
                        part_se_q <= 1'b0;
                        part_tm_q <= 1'b0;
                        state_q   <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign tx_start   = tx_start_q;
    assign tx_data    = tx_data_q;
    assign part_clk   = part_clk_q;
    assign part_rstn  = part_rstn_q;
    assign part_se    = part_se_q;
    assign part_tm    = part_tm_q;
    assign scan_in    = scan_in_q;
    assign part_pis_o = pis_q;
    assign idle       = (state_q == S_IDLE);

endmodule

// File: tb/tb_part_cmd_responder.sv
`timescale 1ns/1ps
module tb_part_cmd_responder;
    localparam int NPIS = 14;
    localparam int NPOS = 11;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              rx_valid = 1'b0;
    logic [7:0]        rx_data = 8'h00;
    logic              tx_ready = 1'b1;
    logic              tx_start;
    logic [7:0]        tx_data;
    logic              part_clk, part_rstn, part_se, part_tm, scan_in, scan_out, idle;
    logic [1:NPIS]     part_pis_o;
    logic [1:NPOS]     part_pos_i = '0;

    int                checks = 0;
    int                errors = 0;
    logic [7:0]        txq[$];
    int                busy = 0;
    int                pulses = 0;
    int                se_pulses = 0;
    longint            rise_t[$];
    logic [5:0]        chain = 6'd0;

    assign scan_out = chain[5];

    always #5 clk = ~clk;

    part_cmd_responder #(.NPIS(NPIS), .NPOS(NPOS), .RST_CYCLES(16), .TIMEOUT_CYCLES(100)) dut (
        .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data),
        .tx_ready(tx_ready), .tx_start(tx_start), .tx_data(tx_data),
        .part_clk(part_clk), .part_rstn(part_rstn), .part_se(part_se), .part_tm(part_tm),
        .scan_in(scan_in), .scan_out(scan_out),
        .part_pis_o(part_pis_o), .part_pos_i(part_pos_i), .idle(idle)
    );

    // uart_tx model: accepts a byte on tx_start, busy for 3 clks.
    always @(negedge clk) begin
        if (rst) begin
            tx_ready = 1'b1;
            busy = 0;
        end else if (tx_start) begin
            txq.push_back(tx_data);
            tx_ready = 1'b0;
            busy = 3;
        end else if (busy > 0) begin
            busy = busy - 1;
            if (busy == 0) tx_ready = 1'b1;
        end
    end

    // Part model: 6-bit scan chain plus pulse monitor.
    always @(posedge part_clk) begin
        pulses = pulses + 1;
        rise_t.push_back($time);
        if (part_se) begin
            se_pulses = se_pulses + 1;
            chain = {chain[4:0], scan_in};
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic gap();
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        int n;
        n = 0;
        while (idle !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        ok = (idle === 1'b1);
    endtask

    task automatic test_reset();
        logic [30:0] got;
        @(negedge clk);
        got = {tx_start, tx_data, part_clk, part_rstn, part_se, part_tm, scan_in, part_pis_o, idle};
        checks++;
        if (got !== {1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 14'd0, 1'b1}) begin
            errors++;
            $display("FAIL reset_values got=%h exp=%h", got, {1'b0, 8'h00, 5'b0, 14'd0, 1'b1});
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (part_rstn !== 1'b1 || idle !== 1'b1) begin
            errors++;
            $display("FAIL rstn_release got rstn=%b idle=%b exp 1 1", part_rstn, idle);
        end
    endtask

    task automatic test_scan();
        string       bits;
        bit          ok;
        logic [47:0] got;
        bits = "101001";
        pulses = 0; se_pulses = 0; txq.delete();
        send_byte("s"); gap(); send_byte(8'h00); gap(); send_byte(8'h06); gap();
        for (int i = 0; i < 6; i++) begin
            send_byte(bits[i]);
            gap();
        end
        wait_idle(200, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL s_idle timeout idle=%b exp 1", idle); end
        checks++;
        if (pulses != 6 || se_pulses != 6) begin
            errors++;
            $display("FAIL s_pulses got=%0d se=%0d exp 6 6", pulses, se_pulses);
        end
        checks++;
        if (chain !== 6'b101001) begin
            errors++;
            $display("FAIL s_chain got=%b exp 101001", chain);
        end
        checks++;
        if (txq.size() != 0 || part_se !== 1'b0 || part_tm !== 1'b0) begin
            errors++;
            $display("FAIL s_quiet tx=%0d se=%b tm=%b exp 0 0 0", txq.size(), part_se, part_tm);
        end

        pulses = 0; se_pulses = 0;
        send_byte("g"); gap(); send_byte(8'h00); gap(); send_byte(8'h06);
        wait_idle(500, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL g_idle timeout idle=%b exp 1", idle); end
        got = '0;
        foreach (txq[i]) got = {got[39:0], txq[i]};
        checks++;
        if (txq.size() != 6 || got !== 48'h313031303031) begin
            errors++;
            $display("FAIL g_reply n=%0d got=%h exp 6 313031303031", txq.size(), got);
        end
        checks++;
        if (se_pulses != 6 || part_se !== 1'b0) begin
            errors++;
            $display("FAIL g_pulses got=%0d se=%b exp 6 0", se_pulses, part_se);
        end
    endtask

    task automatic test_exec();
        bit ok;
        bit spacing_ok;
        pulses = 0; se_pulses = 0; rise_t.delete(); txq.delete();
        send_byte("e"); gap(); send_byte(8'h00); gap(); send_byte(8'h04);
        wait_idle(100, ok);
        repeat (2) @(negedge clk);
        checks++;
        if (!ok || pulses != 4 || se_pulses != 0) begin
            errors++;
            $display("FAIL e_pulses ok=%0b got=%0d se=%0d exp 1 4 0", ok, pulses, se_pulses);
        end
        spacing_ok = (rise_t.size() == 4);
        for (int i = 1; i < rise_t.size(); i++) if (rise_t[i] - rise_t[i-1] != 20) spacing_ok = 0;
        checks++;
        if (!spacing_ok || txq.size() != 0) begin
            errors++;
            $display("FAIL e_spacing ok=%0b tx=%0d exp 1 0 (2-clk period)", spacing_ok, txq.size());
        end

        pulses = 0;
        send_byte("e"); gap(); send_byte(8'h00); gap(); send_byte(8'h00);
        checks++;
        if (idle !== 1'b1) begin errors++; $display("FAIL n0_idle got=%b exp 1", idle); end
        repeat (10) @(negedge clk);
        checks++;
        if (pulses != 0 || txq.size() != 0) begin
            errors++;
            $display("FAIL n0_quiet pulses=%0d tx=%0d exp 0 0", pulses, txq.size());
        end
    endtask

    task automatic test_pi_po();
        bit    ok;
        string exp_s;
        int    bad;
        send_byte("i"); gap(); send_byte(8'h00); gap(); send_byte(8'h10);
        for (int i = 0; i < 16; i++) send_byte("1");
        wait_idle(50, ok);
        checks++;
        if (!ok || part_pis_o !== 14'h3FFF) begin
            errors++;
            $display("FAIL pi_ones got=%b exp 11111111111111", part_pis_o);
        end
        send_byte("i"); gap(); send_byte(8'h00); gap(); send_byte(8'h03);
        send_byte("0"); send_byte("1"); send_byte("0");
        wait_idle(50, ok);
        checks++;
        if (!ok || part_pis_o !== 14'b01011111111111) begin
            errors++;
            $display("FAIL pi_partial got=%b exp 01011111111111", part_pis_o);
        end

        part_pos_i = 11'b10110011101;
        exp_s = "1011001110100";
        txq.delete();
        send_byte("o"); gap(); send_byte(8'h00); gap(); send_byte(8'h0D);
        wait_idle(2000, ok);
        bad = 0;
        if (txq.size() == 13) begin
            for (int i = 0; i < 13; i++) if (txq[i] !== exp_s[i]) bad++;
        end
        checks++;
        if (!ok || txq.size() != 13 || bad != 0) begin
            errors++;
            $display("FAIL po_reply n=%0d wrong=%0d exp 13 0", txq.size(), bad);
        end
    endtask

    task automatic test_cmds();
        bit ok;
        int n;
        txq.delete();
        send_byte("r");
        n = 0;
        while (part_rstn === 1'b0 && n < 100) begin
            n++;
            @(negedge clk);
        end
        checks++;
        if (n != 16) begin errors++; $display("FAIL r_low got=%0d clks exp 16", n); end
        wait_idle(100, ok);
        checks++;
        if (!ok || txq.size() != 1 || txq[0] !== 8'h0A) begin
            errors++;
            $display("FAIL r_reply n=%0d got=%h exp 1 0a", txq.size(), (txq.size() > 0) ? txq[0] : 8'hxx);
        end

        txq.delete();
        send_byte("x");
        wait_idle(100, ok);
        checks++;
        if (!ok || txq.size() != 1 || txq[0] !== 8'h3F) begin
            errors++;
            $display("FAIL x_reply n=%0d got=%h exp 1 3f", txq.size(), (txq.size() > 0) ? txq[0] : 8'hxx);
        end

        txq.delete();
        send_byte("p");
        checks++;
        if (idle !== 1'b1) begin errors++; $display("FAIL p_idle got=%b exp 1", idle); end
        repeat (20) @(negedge clk);
        checks++;
        if (txq.size() != 0) begin errors++; $display("FAIL p_noreply n=%0d exp 0", txq.size()); end
    endtask

    task automatic test_free();
        int snap;
        logic [30:0] got;
        pulses = 0; se_pulses = 0; txq.delete();
        send_byte("f");
        repeat (1000) @(negedge clk);
        checks++;
        if (pulses < 495 || pulses > 505 || se_pulses != 0) begin
            errors++;
            $display("FAIL f_run pulses=%0d se=%0d exp ~500 0", pulses, se_pulses);
        end
        send_byte("x");
        repeat (10) @(negedge clk);
        send_byte("p");
        @(negedge clk);
        checks++;
        if (idle !== 1'b1 || part_clk !== 1'b0) begin
            errors++;
            $display("FAIL f_stop idle=%b clk=%b exp 1 0", idle, part_clk);
        end
        snap = pulses;
        repeat (10) @(negedge clk);
        checks++;
        if (pulses != snap || txq.size() != 0) begin
            errors++;
            $display("FAIL f_after extra=%0d tx=%0d exp 0 0", pulses - snap, txq.size());
        end

        send_byte("f");
        repeat (51) @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        got = {tx_start, tx_data, part_clk, part_rstn, part_se, part_tm, scan_in, part_pis_o, idle};
        checks++;
        if (got !== {1'b0, 8'h00, 5'b0, 14'd0, 1'b1}) begin
            errors++;
            $display("FAIL f_async_rst got=%h exp=%h", got, {1'b0, 8'h00, 5'b0, 14'd0, 1'b1});
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (idle !== 1'b1 || part_rstn !== 1'b1 || part_clk !== 1'b0) begin
            errors++;
            $display("FAIL f_rst_exit idle=%b rstn=%b clk=%b exp 1 1 0", idle, part_rstn, part_clk);
        end
    endtask

`ifdef PART_CMD_TIMEOUT_EN
    task automatic test_timeout();
        int n;
        bit ok;
        txq.delete();
        send_byte("s");
        n = 0;
        while (txq.size() == 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        wait_idle(50, ok);
        checks++;
        if (!ok || txq.size() != 1 || txq[0] !== 8'h21 || n < 95 || n > 110) begin
            errors++;
            $display("FAIL timeout n=%0d clks tx=%0d exp ~100 1 '!'", n, txq.size());
        end
    endtask
`endif

    initial begin
        test_reset();
        test_scan();
        test_exec();
        test_pi_po();
        test_cmds();
`ifdef PART_CMD_TIMEOUT_EN
        test_timeout();
`endif
        test_free();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
